// File: rtl/prog_boot_harness.sv
// prog_boot_harness
// Boot-and-run controller for the in-order core. A program is streamed into
// instruction memory while the core is held in reset. The core is then released
// and runs under a watchdog until it stores to TOHOST_ADDR or the cycle budget
// runs out. The block reports pass/fail, the result word and the run cycle count.
//
// Ports
//   clk, reset       clock, asynchronous active-high reset
//   start            one-cycle pulse, accepted in IDLE or DONE only
//   prog_len         program length in words, sampled when start is accepted
//   ld_valid/ld_data load-stream word; ld_ready is high only in LOAD
//   imem_we/waddr/wdata  registered instruction-memory write port
//   core_resetn      active-low core reset, high only while the core runs
//   dmem_we/addr/wdata   snooped core store port
//   busy/done        run status
//   pass/err/timeout run outcome flags
//   cycles/result    run cycle count and data of the terminating store
module prog_boot_harness #(
   parameter int          ADDR_W      = 10,
   parameter int          DATA_W      = 32,
   parameter int          MAX_WORDS   = 1 << ADDR_W,
   parameter int          RESET_HOLD  = 4,
   parameter int          TIMEOUT     = 4096,
   parameter logic [31:0] TOHOST_ADDR = 32'h0000_0FFC,
   parameter int          CNT_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   prog_len,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              core_resetn,
   input  logic              dmem_we,
   input  logic [31:0]       dmem_addr,
   input  logic [31:0]       dmem_wdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              err,
   output logic              timeout,
   output logic [CNT_W-1:0]  cycles,
   output logic [31:0]       result
);

   localparam int              HOLD_W    = (RESET_HOLD < 2) ? 1 : $clog2(RESET_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
   localparam logic [ADDR_W:0] MAX_LEN   = (ADDR_W + 1)'(MAX_WORDS);
   localparam logic [ADDR_W:0] LEN_ONE   = (ADDR_W + 1)'(1);
   localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, DONE} state_t;

   state_t            state;
   state_t            next_state;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   widx;
   logic [HOLD_W-1:0] hold_cnt;

   logic start_ok;
   logic len_bad;
   logic handshake;
   logic last_word;
   logic hold_done;
   logic tohost_hit;
   logic wd_hit;

   // Decoded conditions shared by the next-state logic and the datapath.
   assign start_ok   = start && (state == IDLE || state == DONE);
   assign len_bad    = (prog_len == '0) || (prog_len > MAX_LEN);
   assign handshake  = ld_valid && (state == LOAD);
   assign last_word  = (widx == (len_q - LEN_ONE));
   assign hold_done  = (hold_cnt == HOLD_LAST);
   assign tohost_hit = dmem_we && (dmem_addr == TOHOST_ADDR);
   assign wd_hit     = (cycles == CYC_LAST);

   assign ld_ready = (state == LOAD);
   assign busy     = (state == LOAD) || (state == HOLD) || (state == RUN);
   assign done     = (state == DONE);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. A bad length skips the load entirely and reports err.
   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: begin
            if (start_ok) begin
               next_state = len_bad ? DONE : LOAD;
            end
         end
         LOAD: begin
            if (handshake && last_word) begin
               next_state = HOLD;
            end
         end
         HOLD: begin
            if (hold_done) begin
               next_state = RUN;
            end
         end
         RUN: begin
            if (tohost_hit || wd_hit) begin
               next_state = DONE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Datapath. core_resetn follows the next state so it is a clean register that
   // is high exactly while the FSM sits in RUN. The store check comes before the
   // watchdog check so a simultaneous TOHOST store wins over the timeout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_q       <= '0;
         widx        <= '0;
         hold_cnt    <= '0;
         imem_we     <= 1'b0;
         imem_waddr  <= '0;
         imem_wdata  <= '0;
         core_resetn <= 1'b0;
         pass        <= 1'b0;
         err         <= 1'b0;
         timeout     <= 1'b0;
         cycles      <= '0;
         result      <= '0;
      end else begin
         imem_we     <= 1'b0;
         core_resetn <= (next_state == RUN);
         case (state)
            IDLE, DONE: begin
               if (start_ok) begin
                  len_q   <= prog_len;
                  widx    <= '0;
                  pass    <= 1'b0;
                  err     <= len_bad;
                  timeout <= 1'b0;
                  cycles  <= '0;
                  result  <= '0;
               end
            end
            LOAD: begin
               hold_cnt <= '0;
               if (handshake) begin
                  imem_we    <= 1'b1;
                  imem_waddr <= widx[ADDR_W-1:0];
                  imem_wdata <= ld_data;
                  widx       <= widx + LEN_ONE;
               end
            end
            HOLD: begin
               hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            RUN: begin
               if (tohost_hit) begin
                  result <= dmem_wdata;
                  pass   <= (dmem_wdata == 32'd1);
               end else if (wd_hit) begin
                  timeout <= 1'b1;
               end else begin
                  cycles <= cycles + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_boot_harness.sv
// tb_prog_boot_harness
// Directed bench for prog_boot_harness: loads the 8-word swap program, runs a
// small core model that issues stores at chosen RUN cycles, and checks the
// outcome registers. Covers bad lengths and a reset in the middle of a load.
module tb_prog_boot_harness;

   localparam int ADDR_W     = 10;
   localparam int DATA_W     = 32;
   localparam int RESET_HOLD = 4;
   localparam int TIMEOUT    = 64;
   localparam int CNT_W      = 32;

   logic              clk;
   logic              reset;
   logic              start;
   logic [ADDR_W:0]   prog_len;
   logic              ld_valid;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [DATA_W-1:0] imem_wdata;
   logic              core_resetn;
   logic              dmem_we;
   logic [31:0]       dmem_addr;
   logic [31:0]       dmem_wdata;
   logic              busy;
   logic              done;
   logic              pass;
   logic              err;
   logic              timeout;
   logic [CNT_W-1:0]  cycles;
   logic [31:0]       result;

   prog_boot_harness #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_HOLD(RESET_HOLD),
      .TIMEOUT(TIMEOUT), .TOHOST_ADDR(32'h0000_0FFC), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .prog_len(prog_len),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
      .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .core_resetn(core_resetn), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .busy(busy), .done(done), .pass(pass),
      .err(err), .timeout(timeout), .cycles(cycles), .result(result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] prog [8] = '{32'h01908093, 32'h04b10113, 32'h002080b3, 32'h40208133,
                             32'h402080b3, 32'hffd08093, 32'h0020a023, 32'h0000a183};

   // Record every imem write on the falling edge, away from the active edge.
   logic [ADDR_W-1:0] wr_addr_q [$];
   logic [DATA_W-1:0] wr_data_q [$];
   always @(negedge clk) begin
      if (imem_we) begin
         wr_addr_q.push_back(imem_waddr);
         wr_data_q.push_back(imem_wdata);
      end
   end

   typedef struct {
      int          st_cycle;
      logic [31:0] st_data;
      int          decoy_cycle;
      logic        exp_pass;
      logic        exp_timeout;
      logic [31:0] exp_cycles;
      logic [31:0] exp_result;
   } vec_t;

   vec_t vecs [5];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start a load, stream the words, then count HOLD cycles and verify the writes.
   task automatic loadProgram(input int len, input bit gap);
      int n;
      wr_addr_q.delete();
      wr_data_q.delete();
      prog_len = (ADDR_W + 1)'(len);
      start    = 1'b1;
      tick();
      start    = 1'b0;
      checkOutput("ld_ready_in_load", ld_ready, 1);
      for (int i = 0; i < len; i++) begin
         if (gap) begin
            ld_valid = 1'b0;
            tick();
         end
         ld_valid = 1'b1;
         ld_data  = prog[i % 8];
         tick();
      end
      ld_valid = 1'b0;
      checkOutput("ld_ready_after_last", ld_ready, 0);
      n = 0;
      while (!core_resetn && n < 20) begin
         tick();
         n++;
      end
      checkOutput("hold_cycles", n, RESET_HOLD);
      checkOutput("busy_in_run", busy, 1);
      checkOutput("imem_write_count", wr_addr_q.size(), len);
      for (int i = 0; i < len; i++) begin
         if (i < wr_addr_q.size()) begin
            checkOutput($sformatf("imem_waddr[%0d]", i), 32'(wr_addr_q[i]), i);
            checkOutput($sformatf("imem_wdata[%0d]", i), wr_data_q[i], prog[i % 8]);
         end
      end
   endtask

   // Core model: called in RUN cycle 0, issues the decoy and TOHOST stores.
   task automatic runCore(input int st_cycle, input logic [31:0] st_data, input int decoy_cycle);
      int k;
      k = 0;
      while (!done && k < 200) begin
         dmem_we    = 1'b0;
         dmem_addr  = 32'h0;
         dmem_wdata = 32'h0;
         if (k == decoy_cycle) begin
            dmem_we    = 1'b1;
            dmem_addr  = 32'h0000_0FF8;
            dmem_wdata = 32'h1;
         end
         if (k == st_cycle) begin
            dmem_we    = 1'b1;
            dmem_addr  = 32'h0000_0FFC;
            dmem_wdata = st_data;
         end
         tick();
         k++;
      end
      dmem_we    = 1'b0;
      dmem_addr  = 32'h0;
      dmem_wdata = 32'h0;
      if (!done) checkOutput("run_terminated", done, 1);
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      loadProgram(8, idx == 0);
      runCore(v.st_cycle, v.st_data, v.decoy_cycle);
      checkOutput($sformatf("v%0d_done", idx), done, 1);
      checkOutput($sformatf("v%0d_pass", idx), pass, v.exp_pass);
      checkOutput($sformatf("v%0d_timeout", idx), timeout, v.exp_timeout);
      checkOutput($sformatf("v%0d_cycles", idx), cycles, v.exp_cycles);
      checkOutput($sformatf("v%0d_result", idx), result, v.exp_result);
      checkOutput($sformatf("v%0d_err", idx), err, 0);
      checkOutput($sformatf("v%0d_core_resetn", idx), core_resetn, 0);
      checkOutput($sformatf("v%0d_busy", idx), busy, 0);
      tick();
      tick();
      checkOutput($sformatf("v%0d_cycles_hold", idx), cycles, v.exp_cycles);
      checkOutput($sformatf("v%0d_result_hold", idx), result, v.exp_result);
   endtask

   initial begin
      vecs[0] = '{37, 32'h1,         -1, 1'b1, 1'b0, 32'd37, 32'h1};
      vecs[1] = '{20, 32'h7,         10, 1'b0, 1'b0, 32'd20, 32'h7};
      vecs[2] = '{-1, 32'h0,         -1, 1'b0, 1'b1, 32'd63, 32'h0};
      vecs[3] = '{63, 32'h1,         -1, 1'b1, 1'b0, 32'd63, 32'h1};
      vecs[4] = '{0,  32'hDEAD_BEEF, -1, 1'b0, 1'b0, 32'd0,  32'hDEAD_BEEF};

      reset      = 1'b1;
      start      = 1'b0;
      prog_len   = '0;
      ld_valid   = 1'b0;
      ld_data    = '0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      tick();
      tick();
      checkOutput("rst_core_resetn", core_resetn, 0);
      checkOutput("rst_ld_ready", ld_ready, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_imem_we", imem_we, 0);
      checkOutput("rst_cycles", cycles, 0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i], i);
      end

      // Zero and oversized lengths report err without touching imem.
      wr_addr_q.delete();
      prog_len = '0;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      checkOutput("len0_done", done, 1);
      checkOutput("len0_err", err, 1);
      checkOutput("len0_busy", busy, 0);
      checkOutput("len0_pass", pass, 0);
      prog_len = (ADDR_W + 1)'(1025);
      start    = 1'b1;
      tick();
      start    = 1'b0;
      checkOutput("lenbig_err", err, 1);
      checkOutput("lenbig_done", done, 1);
      tick();
      tick();
      checkOutput("bad_len_no_writes", wr_addr_q.size(), 0);

      // Reset in the middle of a load clears everything immediately.
      prog_len = (ADDR_W + 1)'(8);
      start    = 1'b1;
      tick();
      start    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ld_valid = 1'b1;
         ld_data  = prog[i];
         tick();
      end
      ld_valid = 1'b0;
      checkOutput("midload_imem_we", imem_we, 1);
      reset = 1'b1;
      #1;
      checkOutput("midrst_imem_we", imem_we, 0);
      checkOutput("midrst_ld_ready", ld_ready, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_err", err, 0);
      checkOutput("midrst_core_resetn", core_resetn, 0);
      checkOutput("midrst_imem_waddr", 32'(imem_waddr), 0);
      tick();
      reset = 1'b0;
      tick();

      // Restart reloads from word 0 and runs to a passing store.
      loadProgram(8, 1'b0);
      runCore(5, 32'h1, -1);
      checkOutput("restart_pass", pass, 1);
      checkOutput("restart_cycles", cycles, 5);
      checkOutput("restart_timeout", timeout, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
